// File: rtl/amiga_key_queue.sv
// Keycode FIFO and Amiga handshake pacer in front of the keyboard serializer.
// Adds power-up stream codes, overflow reporting and lost-sync resend.
module amiga_key_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GAP        = 2048,
  parameter int unsigned TIMEOUT    = 1001000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk7_en,
  input  logic                  in_strobe,
  input  logic [7:0]            in_data,
  input  logic                  keyboard_disabled,
  input  logic                  keyack,
  output logic                  key_strobe,
  output logic [7:0]            key_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  busy
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_INIT0 = 8'hFD;
  localparam logic [7:0] CODE_INIT1 = 8'hFE;
  localparam logic [7:0] CODE_OVF   = 8'hFA;
  localparam logic [7:0] CODE_SYNC  = 8'hF9;

  typedef enum logic [2:0] {S_INIT0, S_INIT1, S_IDLE, S_WAIT, S_SYNC} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   tick_cnt, cnt_next;
  logic [7:0]      last;
  logic            ack_seen, ack_ok, ovf, resend, have_last, ret_init1;
  logic            empty, full, push, pop, overflow;
  logic            emit, emit_ret_init1, clr_ovf, set_resend, clr_resend;
  logic [7:0]      emit_code;

  assign empty    = (fifo_level == LW'(0));
  assign full     = (fifo_level == LW'(DEPTH));
  assign push     = in_strobe & ~keyboard_disabled & (~full | pop);
  assign overflow = in_strobe & ~keyboard_disabled & full & ~pop;
  assign cnt_next = tick_cnt + CW'(1);
  // A keyack in the deciding cycle counts as well as one latched earlier.
  assign ack_ok   = ack_seen | keyack;

  always_comb begin
    state_next     = state;
    emit           = 1'b0;
    emit_code      = 8'h00;
    emit_ret_init1 = 1'b0;
    pop            = 1'b0;
    clr_ovf        = 1'b0;
    set_resend     = 1'b0;
    clr_resend     = 1'b0;
    if (clk7_en) begin
      unique case (state)
        S_INIT0: begin
          emit           = 1'b1;
          emit_code      = CODE_INIT0;
          emit_ret_init1 = 1'b1;
          state_next     = S_WAIT;
        end
        S_INIT1: begin
          emit       = 1'b1;
          emit_code  = CODE_INIT1;
          state_next = S_WAIT;
        end
        S_IDLE: begin
          if (resend) begin
            emit       = 1'b1;
            emit_code  = last;
            clr_resend = 1'b1;
            state_next = S_WAIT;
          end else if (ovf) begin
            emit       = 1'b1;
            emit_code  = CODE_OVF;
            clr_ovf    = 1'b1;
            state_next = S_WAIT;
          end else if (!empty) begin
            emit       = 1'b1;
            emit_code  = mem[rd_ptr];
            pop        = 1'b1;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          // Leave one tick early so the next emit lands exactly GAP ticks on.
          if (ack_ok && cnt_next >= CW'(GAP - 1)) begin
            state_next = ret_init1 ? S_INIT1 : S_IDLE;
          end else if (cnt_next >= CW'(TIMEOUT)) begin
            state_next = S_SYNC;
          end
        end
        S_SYNC: begin
          emit           = 1'b1;
          emit_code      = CODE_SYNC;
          emit_ret_init1 = ret_init1;
          set_resend     = have_last;
          state_next     = S_WAIT;
        end
        default: state_next = S_INIT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT0;
      busy       <= 1'b1;
      key_strobe <= 1'b0;
      key_data   <= 8'h00;
      fifo_level <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tick_cnt   <= '0;
      ack_seen   <= 1'b0;
      ovf        <= 1'b0;
      resend     <= 1'b0;
      have_last  <= 1'b0;
      ret_init1  <= 1'b0;
      last       <= 8'h00;
    end else begin
      state      <= state_next;
      busy       <= (state_next != S_IDLE);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last      <= emit_code;
        have_last <= 1'b1;
      end
      if (clk7_en) begin
        key_strobe <= emit;
        if (emit) begin
          key_data  <= emit_code;
          tick_cnt  <= '0;
          ret_init1 <= emit_ret_init1;
        end else if (state == S_WAIT) begin
          tick_cnt <= cnt_next;
        end
      end
      if (emit)                         ack_seen <= 1'b0;
      else if (state == S_WAIT && keyack) ack_seen <= 1'b1;
      if (clr_resend) resend <= 1'b0;
      if (set_resend) resend <= 1'b1;
      if (clr_ovf)    ovf    <= 1'b0;
      if (overflow)   ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_amiga_key_queue.sv
// Directed bench for amiga_key_queue with shortened GAP/TIMEOUT.
module tb_amiga_key_queue;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned GAP        = 16;
  localparam int unsigned TIMEOUT    = 60;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                clk7_en = 1'b0;
  logic                in_strobe = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                keyboard_disabled = 1'b0;
  logic                keyack = 1'b0;
  logic                key_strobe;
  logic [7:0]          key_data;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                busy;

  int vectors = 0;
  int miscompares = 0;
  int tick = 0;
  logic [7:0] q_data[$];
  int         q_tick[$];
  bit   auto_ack = 1'b0;
  bit   ack_req = 1'b0;
  bit   ack_arm = 1'b0;
  int   ack_delay = 0;
  int   ack_at = 0;
  logic prev_s = 1'b0;

  amiga_key_queue #(.DEPTH_LOG2(DEPTH_LOG2), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .in_strobe(in_strobe),
    .in_data(in_data), .keyboard_disabled(keyboard_disabled), .keyack(keyack),
    .key_strobe(key_strobe), .key_data(key_data), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    clk7_en = ~clk7_en;
  end

  always @(posedge clk) if (clk7_en) tick <= tick + 1;

  // Records each strobe with its tick and answers with a one-clk keyack.
  initial forever begin
    @(negedge clk);
    keyack = 1'b0;
    if (key_strobe && !prev_s) begin
      q_data.push_back(key_data);
      q_tick.push_back(tick);
      if (auto_ack) begin
        ack_arm = 1'b1;
        ack_at  = tick + ack_delay;
      end
    end
    prev_s = key_strobe;
    if (ack_req) begin
      keyack  = 1'b1;
      ack_req = 1'b0;
    end else if (ack_arm && tick >= ack_at) begin
      keyack  = 1'b1;
      ack_arm = 1'b0;
    end
  end

  function automatic logic [7:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : 8'hxx;
  endfunction

  function automatic int qt(input int i);
    return (i < q_tick.size()) ? q_tick[i] : -1000;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_tick.delete();
  endtask

  task automatic push_code(input logic [7:0] d);
    @(negedge clk);
    in_strobe = 1'b1;
    in_data   = d;
  endtask

  task automatic push_end();
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (q_data.size() < n) begin
      miscompares++;
      $display("FAIL wait_strobes got %0d strobes need %0d", q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 4;
    if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got %b exp 0", key_strobe); end
    if (key_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", key_data); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b exp 1", busy); end
  endtask

  task automatic test_init();
    clear_q();
    auto_ack  = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    reset = 1'b0;
    wait_strobes(2, 200);
    vectors += 3;
    if (qd(0) !== 8'hFD) begin miscompares++; $display("FAIL init_code0 got %h exp FD", qd(0)); end
    if (qd(1) !== 8'hFE) begin miscompares++; $display("FAIL init_code1 got %h exp FE", qd(1)); end
    if (qt(1) - qt(0) != GAP) begin miscompares++; $display("FAIL init_gap got %0d exp %0d", qt(1) - qt(0), GAP); end
    repeat (40) @(negedge clk);
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL init_busy got %b exp 0", busy); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL init_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    ack_delay = 5;
    push_code(8'h45);
    push_code(8'hC5);
    push_end();
    wait_strobes(2, 200);
    vectors += 3;
    if (qd(0) !== 8'h45) begin miscompares++; $display("FAIL b2b_code0 got %h exp 45", qd(0)); end
    if (qd(1) !== 8'hC5) begin miscompares++; $display("FAIL b2b_code1 got %h exp C5", qd(1)); end
    if (qt(1) - qt(0) != GAP) begin miscompares++; $display("FAIL b2b_gap got %0d exp %0d", qt(1) - qt(0), GAP); end
    ack_delay = 0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_overflow();
    clear_q();
    auto_ack = 1'b0;
    push_code(8'h30);
    push_end();
    wait_strobes(1, 50);
    for (int i = 0; i < 17; i++) push_code(8'(i + 1));
    push_end();
    vectors++;
    if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL ovf_level got %0d exp 16", fifo_level); end
    auto_ack  = 1'b1;
    ack_delay = 0;
    ack_req   = 1'b1;
    wait_strobes(18, 900);
    vectors++;
    if (qd(1) !== 8'hFA) begin miscompares++; $display("FAIL ovf_code got %h exp FA", qd(1)); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (qd(i + 2) !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL ovf_order[%0d] got %h exp %h", i, qd(i + 2), 8'(i + 1));
      end
    end
    repeat (60) @(negedge clk);
    vectors += 2;
    if (q_data.size() != 18) begin miscompares++; $display("FAIL ovf_count got %0d exp 18", q_data.size()); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL ovf_drain got %0d exp 0", fifo_level); end
  endtask

  task automatic test_timeout();
    clear_q();
    auto_ack = 1'b0;
    push_code(8'h20);
    push_end();
    wait_strobes(1, 50);
    push_code(8'h21);
    push_end();
    wait_strobes(2, 300);
    vectors += 2;
    if (qd(1) !== 8'hF9) begin miscompares++; $display("FAIL sync_code got %h exp F9", qd(1)); end
    if (qt(1) - qt(0) != TIMEOUT + 1) begin miscompares++; $display("FAIL sync_gap got %0d exp %0d", qt(1) - qt(0), TIMEOUT + 1); end
    auto_ack  = 1'b1;
    ack_delay = 0;
    ack_req   = 1'b1;
    wait_strobes(3, 100);
    vectors += 3;
    if (qd(2) !== 8'h20) begin miscompares++; $display("FAIL resend_code got %h exp 20", qd(2)); end
    if (qt(2) - qt(1) != GAP) begin miscompares++; $display("FAIL resend_gap got %0d exp %0d", qt(2) - qt(1), GAP); end
    if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL resend_level got %0d exp 1", fifo_level); end
    wait_strobes(4, 100);
    vectors++;
    if (qd(3) !== 8'h21) begin miscompares++; $display("FAIL after_resend got %h exp 21", qd(3)); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    clear_q();
    ack_delay = TIMEOUT - 1;
    push_code(8'h22);
    push_end();
    wait_strobes(1, 50);
    ack_delay = 0;
    push_code(8'h23);
    push_end();
    wait_strobes(2, 300);
    vectors += 2;
    if (qd(1) !== 8'h23) begin miscompares++; $display("FAIL edge_ack_code got %h exp 23", qd(1)); end
    if (qt(1) - qt(0) != TIMEOUT + 1) begin miscompares++; $display("FAIL edge_ack_gap got %0d exp %0d", qt(1) - qt(0), TIMEOUT + 1); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_disabled();
    clear_q();
    keyboard_disabled = 1'b1;
    push_code(8'h11);
    push_code(8'h12);
    push_code(8'h13);
    push_end();
    repeat (40) @(negedge clk);
    vectors += 2;
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL dis_level got %0d exp 0", fifo_level); end
    if (q_data.size() != 0) begin miscompares++; $display("FAIL dis_strobes got %0d exp 0", q_data.size()); end
    keyboard_disabled = 1'b0;
    push_code(8'h10);
    push_end();
    wait_strobes(1, 50);
    vectors++;
    if (qd(0) !== 8'h10) begin miscompares++; $display("FAIL dis_code got %h exp 10", qd(0)); end
    repeat (60) @(negedge clk);
    vectors++;
    if (q_data.size() != 1) begin miscompares++; $display("FAIL dis_single got %0d exp 1", q_data.size()); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    auto_ack = 1'b0;
    push_code(8'h50);
    push_end();
    wait_strobes(1, 50);
    for (int i = 0; i < 5; i++) push_code(8'(8'h51 + i));
    push_end();
    vectors++;
    if (fifo_level !== 5'd5) begin miscompares++; $display("FAIL mid_level got %0d exp 5", fifo_level); end
    reset = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL mid_strobe got %b exp 0", key_strobe); end
    if (key_data !== 8'h00) begin miscompares++; $display("FAIL mid_data got %h exp 00", key_data); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL mid_rlevel got %0d exp 0", fifo_level); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b exp 1", busy); end
    repeat (2) @(negedge clk);
    clear_q();
    auto_ack  = 1'b1;
    ack_delay = 0;
    reset = 1'b0;
    wait_strobes(2, 200);
    vectors += 2;
    if (qd(0) !== 8'hFD) begin miscompares++; $display("FAIL mid_init0 got %h exp FD", qd(0)); end
    if (qd(1) !== 8'hFE) begin miscompares++; $display("FAIL mid_init1 got %h exp FE", qd(1)); end
    repeat (100) @(negedge clk);
    vectors += 2;
    if (q_data.size() != 2) begin miscompares++; $display("FAIL mid_stale got %0d strobes exp 2", q_data.size()); end
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL mid_final got %0d exp 0", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_timeout_boundary();
    test_disabled();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
